// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the register file / scoreboard block.
package regfile_scoreboard_pkg;

    localparam int RF_ADDR_LEN_DEF = 5;
    localparam int RF_DATA_LEN_DEF = 32;
    localparam int X0_IDX          = 0;
    localparam int NUM_RD_MAX      = 4;

endpackage

// File: rtl/regfile_busy_table.sv
// Busy (pending-write) table with per-port busy lookup, issue handshake and
// an incrementally maintained count of busy registers.
module regfile_busy_table
    import regfile_scoreboard_pkg::*;
#(
    parameter int ADDR_LEN = RF_ADDR_LEN_DEF,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_LEN-1:0] rs_addr,
    output logic [NUM_RD-1:0]        rs_busy,
    input  logic                     issue_valid,
    input  logic [ADDR_LEN-1:0]      issue_rd,
    output logic                     issue_ready,
    input  logic                     wb_en,
    input  logic [ADDR_LEN-1:0]      wb_addr,
    input  logic                     flush,
    output logic [ADDR_LEN:0]        pending_cnt
);

    localparam int                  NREG    = 2 ** ADDR_LEN;
    localparam logic [ADDR_LEN-1:0] X0_ADDR = ADDR_LEN'(X0_IDX);
    localparam logic [ADDR_LEN:0]   CNT_ONE = (ADDR_LEN + 1)'(1);

    logic [NREG-1:0]   busy_q, busy_d;
    logic [ADDR_LEN:0] cnt_q, cnt_d;
    logic              issue_set;
    logic              cnt_inc, cnt_dec;

    // Issue handshake: a busy destination is still acceptable when it is
    // being released by a writeback in this same cycle.
    always_comb begin
        issue_ready = 1'b0;
        if (!rst && !flush) begin
            issue_ready = !busy_q[issue_rd] || (wb_en && (wb_addr == issue_rd));
        end
        issue_set = issue_valid && issue_ready && (issue_rd != X0_ADDR);
    end

    // Next busy state and count: set beats clear on the same register; the
    // count moves only when a bit actually changes, so it always matches
    // popcount(busy_q).
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        cnt_inc = issue_set && !busy_q[issue_rd];
        cnt_dec = wb_en && busy_q[wb_addr] && !(issue_set && (issue_rd == wb_addr));
        if (flush) begin
            busy_d = '0;
            cnt_d  = '0;
        end else begin
            if (wb_en) begin
                busy_d[wb_addr] = 1'b0;
            end
            if (issue_set) begin
                busy_d[issue_rd] = 1'b1;
            end
            if (cnt_inc && !cnt_dec) begin
                cnt_d = cnt_q + CNT_ONE;
            end else if (cnt_dec && !cnt_inc) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Per-port busy lookup; a forwarded writeback makes the source ready now.
    always_comb begin
        logic [ADDR_LEN-1:0] rd_a;
        logic                fwd;
        rs_busy = '0;
        rd_a    = '0;
        fwd     = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_a       = rs_addr[k*ADDR_LEN +: ADDR_LEN];
            fwd        = (BYPASS != 0) && !rst && wb_en && (wb_addr == rd_a) && (rd_a != X0_ADDR);
            rs_busy[k] = !rst && !fwd && busy_q[rd_a];
        end
    end

    assign pending_cnt = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with combinational read ports, optional write-to-read
// forwarding, and a busy-table scoreboard for outstanding writes.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int RF_ADDR_LEN = RF_ADDR_LEN_DEF,
    parameter int RF_DATA_LEN = RF_DATA_LEN_DEF,
    parameter int NUM_RD      = 2,
    parameter int BYPASS      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_RD*RF_ADDR_LEN-1:0] rs_addr,
    output logic [NUM_RD*RF_DATA_LEN-1:0] rs_data,
    output logic [NUM_RD-1:0]             rs_busy,
    input  logic                          issue_valid,
    input  logic [RF_ADDR_LEN-1:0]        issue_rd,
    output logic                          issue_ready,
    input  logic                          wb_en,
    input  logic [RF_ADDR_LEN-1:0]        wb_addr,
    input  logic [RF_DATA_LEN-1:0]        wb_data,
    input  logic                          flush,
    output logic [RF_ADDR_LEN:0]          pending_cnt
);

    localparam int                     NREG    = 2 ** RF_ADDR_LEN;
    localparam logic [RF_ADDR_LEN-1:0] X0_ADDR = RF_ADDR_LEN'(X0_IDX);

    if (NUM_RD < 1 || NUM_RD > NUM_RD_MAX) begin : g_bad_num_rd
        $error("regfile_scoreboard: NUM_RD out of range");
    end

    logic [RF_DATA_LEN-1:0] rf_q [NREG];
    logic [RF_DATA_LEN-1:0] rf_d [NREG];

    // Writeback updates the array regardless of the busy state; x0 is never written.
    always_comb begin
        rf_d = rf_q;
        if (wb_en && (wb_addr != X0_ADDR)) begin
            rf_d[wb_addr] = wb_data;
        end
    end

    // Data array with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    // Read ports: x0 is hardwired to zero; forwarding is suppressed during
    // reset so the ports show the array contents.
    always_comb begin
        logic [RF_ADDR_LEN-1:0] rd_a;
        rs_data = '0;
        rd_a    = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_a = rs_addr[k*RF_ADDR_LEN +: RF_ADDR_LEN];
            if (rd_a == X0_ADDR) begin
                rs_data[k*RF_DATA_LEN +: RF_DATA_LEN] = '0;
            end else if ((BYPASS != 0) && !rst && wb_en && (wb_addr == rd_a)) begin
                rs_data[k*RF_DATA_LEN +: RF_DATA_LEN] = wb_data;
            end else begin
                rs_data[k*RF_DATA_LEN +: RF_DATA_LEN] = rf_q[rd_a];
            end
        end
    end

    regfile_busy_table #(
        .ADDR_LEN (RF_ADDR_LEN),
        .NUM_RD   (NUM_RD),
        .BYPASS   (BYPASS)
    ) u_busy (
        .clk         (clk),
        .rst         (rst),
        .rs_addr     (rs_addr),
        .rs_busy     (rs_busy),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .flush       (flush),
        .pending_cnt (pending_cnt)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard; a forwarding and a non-forwarding
// instance share all inputs.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rs_addr;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;

    logic [63:0] rs_data,  rs_data_nb;
    logic [1:0]  rs_busy,  rs_busy_nb;
    logic        issue_ready, issue_ready_nb;
    logic [5:0]  pending_cnt, pending_cnt_nb;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.RF_ADDR_LEN(5), .RF_DATA_LEN(32), .NUM_RD(2), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .pending_cnt(pending_cnt)
    );

    regfile_scoreboard #(.RF_ADDR_LEN(5), .RF_DATA_LEN(32), .NUM_RD(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_nb), .rs_busy(rs_busy_nb),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready_nb),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .pending_cnt(pending_cnt_nb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; issue_valid = 1'b0; issue_rd = 5'd0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; flush = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        rs_addr = {5'd2, 5'd1};
        tick();
        #1;
        vecs++; if (issue_ready !== 1'b0) begin errs++; $display("FAIL rst_issue_ready got %b want 0", issue_ready); end
        vecs++; if (rs_busy !== 2'b00) begin errs++; $display("FAIL rst_rs_busy got %b want 00", rs_busy); end
        tick();
        rst = 1'b0;
        for (int a = 1; a < 32; a++) begin
            rs_addr = {5'(32 - a), 5'(a)};
            #1;
            vecs++;
            if (rs_data !== 64'd0 || rs_busy !== 2'b00) begin
                errs++; $display("FAIL reset_read x%0d got data=%h busy=%b want 0/00", a, rs_data, rs_busy);
            end
        end
        vecs++; if (pending_cnt !== 6'd0) begin errs++; $display("FAIL reset_pending got %0d want 0", pending_cnt); end
    endtask

    task automatic test_issue_forward();
        idle();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234_5678;
        tick();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd5;
        #1;
        vecs++; if (issue_ready !== 1'b1) begin errs++; $display("FAIL issue5_ready got %b want 1", issue_ready); end
        tick();
        idle();
        issue_rd = 5'd5;
        rs_addr = {5'd0, 5'd5};
        #1;
        vecs++; if (rs_busy[0] !== 1'b1) begin errs++; $display("FAIL x5_busy got %b want 1", rs_busy[0]); end
        vecs++; if (issue_ready !== 1'b0) begin errs++; $display("FAIL x5_issue_ready got %b want 0", issue_ready); end
        vecs++; if (pending_cnt !== 6'd1) begin errs++; $display("FAIL x5_pending got %0d want 1", pending_cnt); end
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        #1;
        vecs++; if (rs_data[31:0] !== 32'hDEAD_BEEF || rs_busy[0] !== 1'b0) begin
            errs++; $display("FAIL fwd_x5 got %h busy=%b want deadbeef busy=0", rs_data[31:0], rs_busy[0]); end
        vecs++; if (rs_data_nb[31:0] !== 32'h1234_5678 || rs_busy_nb[0] !== 1'b1) begin
            errs++; $display("FAIL nofwd_x5 got %h busy=%b want 12345678 busy=1", rs_data_nb[31:0], rs_busy_nb[0]); end
        vecs++; if (issue_ready !== 1'b1) begin errs++; $display("FAIL release_ready got %b want 1", issue_ready); end
        tick();
        idle();
        #1;
        vecs++; if (rs_data_nb[31:0] !== 32'hDEAD_BEEF || rs_busy_nb[0] !== 1'b0 || pending_cnt !== 6'd0) begin
            errs++; $display("FAIL after_wb_x5 got %h busy=%b cnt=%0d want deadbeef 0 0", rs_data_nb[31:0], rs_busy_nb[0], pending_cnt); end
    endtask

    task automatic test_set_wins();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd7;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h11;
        tick();
        idle();
        rs_addr = {5'd0, 5'd7};
        #1;
        vecs++; if (rs_data[31:0] !== 32'h11 || rs_busy[0] !== 1'b1 || pending_cnt !== 6'd1) begin
            errs++; $display("FAIL set_wins_x7 got %h busy=%b cnt=%0d want 11 1 1", rs_data[31:0], rs_busy[0], pending_cnt); end
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h11;
        tick();
        idle();
        #1;
        vecs++; if (pending_cnt !== 6'd0) begin errs++; $display("FAIL x7_release_cnt got %0d want 0", pending_cnt); end
    endtask

    task automatic test_back_to_back();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd8;
        tick();
        #1;
        vecs++; if (issue_ready !== 1'b0) begin errs++; $display("FAIL reissue_x8_ready got %b want 0", issue_ready); end
        wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h88;
        #1;
        vecs++; if (issue_ready !== 1'b1) begin errs++; $display("FAIL x8_release_ready got %b want 1", issue_ready); end
        tick();
        idle();
        rs_addr = {5'd8, 5'd0};
        #1;
        vecs++; if (rs_data[63:32] !== 32'h88 || rs_busy[1] !== 1'b1 || pending_cnt !== 6'd1) begin
            errs++; $display("FAIL x8_reissued got %h busy=%b cnt=%0d want 88 1 1", rs_data[63:32], rs_busy[1], pending_cnt); end
        wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h89;
        tick();
        idle();
        #1;
        vecs++; if (rs_busy[1] !== 1'b0 || pending_cnt !== 6'd0) begin
            errs++; $display("FAIL x8_done got busy=%b cnt=%0d want 0 0", rs_busy[1], pending_cnt); end
    endtask

    task automatic test_flush();
        idle();
        issue_valid = 1'b1;
        issue_rd = 5'd3; tick();
        issue_rd = 5'd4; tick();
        issue_rd = 5'd9; tick();
        idle();
        #1;
        vecs++; if (pending_cnt !== 6'd3) begin errs++; $display("FAIL pre_flush_cnt got %0d want 3", pending_cnt); end
        flush = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h22;
        issue_valid = 1'b1; issue_rd = 5'd10;
        #1;
        vecs++; if (issue_ready !== 1'b0) begin errs++; $display("FAIL flush_ready got %b want 0", issue_ready); end
        tick();
        idle();
        rs_addr = {5'd3, 5'd4};
        #1;
        vecs++; if (pending_cnt !== 6'd0 || rs_busy !== 2'b00) begin
            errs++; $display("FAIL post_flush got cnt=%0d busy=%b want 0 00", pending_cnt, rs_busy); end
        vecs++; if (rs_data[31:0] !== 32'h22) begin errs++; $display("FAIL flush_wb_x4 got %h want 22", rs_data[31:0]); end
        rs_addr = {5'd10, 5'd9};
        #1;
        vecs++; if (rs_busy !== 2'b00) begin errs++; $display("FAIL flush_x9_x10_busy got %b want 00", rs_busy); end
    endtask

    task automatic test_x0();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd2;
        tick();
        idle();
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_FFFF;
        issue_valid = 1'b1; issue_rd = 5'd0;
        rs_addr = {5'd2, 5'd0};
        #1;
        vecs++; if (rs_data[31:0] !== 32'd0 || rs_busy[0] !== 1'b0) begin
            errs++; $display("FAIL x0_no_fwd got %h busy=%b want 0 0", rs_data[31:0], rs_busy[0]); end
        tick();
        idle();
        #1;
        vecs++; if (rs_data[31:0] !== 32'd0 || rs_busy !== 2'b10 || pending_cnt !== 6'd1) begin
            errs++; $display("FAIL x0_after got %h busy=%b cnt=%0d want 0 10 1", rs_data[31:0], rs_busy, pending_cnt); end
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h2;
        tick();
        idle();
        #1;
        vecs++; if (pending_cnt !== 6'd0) begin errs++; $display("FAIL x2_release_cnt got %0d want 0", pending_cnt); end
    endtask

    task automatic test_reset_dominates();
        idle();
        wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h44;
        tick();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd11;
        tick();
        idle();
        rst = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd6;
        wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h33;
        rs_addr = {5'd11, 5'd6};
        #1;
        vecs++; if (issue_ready !== 1'b0 || rs_busy !== 2'b00) begin
            errs++; $display("FAIL in_rst got ready=%b busy=%b want 0 00", issue_ready, rs_busy); end
        vecs++; if (rs_data[31:0] !== 32'h44) begin errs++; $display("FAIL in_rst_x6 got %h want 44", rs_data[31:0]); end
        tick();
        idle();
        #1;
        vecs++; if (rs_data[31:0] !== 32'd0 || rs_busy !== 2'b00 || pending_cnt !== 6'd0) begin
            errs++; $display("FAIL post_rst_x6 got %h busy=%b cnt=%0d want 0 00 0", rs_data[31:0], rs_busy, pending_cnt); end
    endtask

    initial begin
        rs_addr = '0;
        idle();
        rst = 1'b1;
        test_reset();
        test_issue_forward();
        test_set_wins();
        test_back_to_back();
        test_flush();
        test_x0();
        test_reset_dominates();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
